// File: rtl/display_scan_ctrl.sv
// ============================================================================
// display_scan_ctrl
//   Time-multiplexed 7-segment scan controller, double-buffered BCD frame.
//   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module display_scan_ctrl #(
   parameter int N_DIGITS    = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_CYC   = 16,
   parameter bit DIG_ACT_LOW = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*N_DIGITS-1:0]   bcd_in,
   input  logic [N_DIGITS-1:0]     dp_in,
   input  logic                    lz_en,
   output logic [7:0]              seg_out,
   output logic [N_DIGITS-1:0]     dig_sel,
   output logic                    frame_done,
   output logic                    pending
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(N_DIGITS);

   localparam logic [CW-1:0]       c_cnt_last   = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0]       c_blank_last = CW'(BLANK_CYC - 1);
   localparam logic [IW-1:0]       c_idx_last   = IW'(N_DIGITS - 1);
   localparam logic [N_DIGITS-1:0] c_dig_off    = DIG_ACT_LOW ? '1 : '0;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BLANK = 2'd1;
   localparam logic [1:0] S_SHOW  = 2'd2;

   logic [1:0]            r_state, w_state_nxt;
   logic [CW-1:0]         r_cnt;
   logic [IW-1:0]         r_idx;
   logic [4*N_DIGITS-1:0] r_sh_bcd, r_act_bcd;
   logic [N_DIGITS-1:0]   r_sh_dp, r_act_dp;
   logic                  r_pending;

   logic                  w_wrap, w_start, w_swap;
   logic [3:0]            w_digit;
   logic                  w_dp;
   logic [N_DIGITS-1:0]   w_lz;
   logic                  w_lz_cur;
   logic [N_DIGITS-1:0]   w_onehot;
   logic [7:0]            w_seg_nxt;
   logic [N_DIGITS-1:0]   w_dig_nxt;

   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'd0:    seg7 = 7'b1111110;
         4'd1:    seg7 = 7'b0110000;
         4'd2:    seg7 = 7'b1101101;
         4'd3:    seg7 = 7'b1111001;
         4'd4:    seg7 = 7'b0110011;
         4'd5:    seg7 = 7'b1011011;
         4'd6:    seg7 = 7'b1011111;
         4'd7:    seg7 = 7'b1110000;
         4'd8:    seg7 = 7'b1111111;
         4'd9:    seg7 = 7'b1110011;
         default: seg7 = 7'b0000000;
      endcase
   endfunction

   assign w_wrap  = enable && (r_state == S_SHOW) && (r_cnt == c_cnt_last) && (r_idx == c_idx_last);
   assign w_start = enable && (r_state == S_IDLE);
   // The shadow only reaches the active buffer between frames, so a frame never tears.
   assign w_swap  = (w_wrap || w_start) && r_pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!enable) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  w_state_nxt = S_BLANK;
            S_BLANK: if (r_cnt == c_blank_last) w_state_nxt = S_SHOW;
            S_SHOW:  if (r_cnt == c_cnt_last)   w_state_nxt = S_BLANK;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Slot counter spans the blank and show phases so every slot is REFRESH_DIV cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (!enable || r_state == S_IDLE) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (r_cnt == c_cnt_last) begin
         r_cnt <= '0;
         r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh_bcd  <= '0;
         r_sh_dp   <= '0;
         r_act_bcd <= '0;
         r_act_dp  <= '0;
         r_pending <= 1'b0;
      end else begin
         if (load) begin
            r_sh_bcd <= bcd_in;
            r_sh_dp  <= dp_in;
         end
         if (w_swap) begin
            r_act_bcd <= r_sh_bcd;
            r_act_dp  <= r_sh_dp;
         end
         if (load)        r_pending <= 1'b1;
         else if (w_swap) r_pending <= 1'b0;
      end
   end

   always_comb begin
      w_digit = '0;
      w_dp    = 1'b0;
      w_lz    = '0;
      w_lz[N_DIGITS-1] = (r_act_bcd[4*N_DIGITS-1 -: 4] == 4'd0);
      for (int i = N_DIGITS - 2; i >= 1; i--)
         w_lz[i] = w_lz[i+1] && (r_act_bcd[4*i +: 4] == 4'd0);
      w_lz[0] = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (r_idx == IW'(i)) begin
            w_digit = r_act_bcd[4*i +: 4];
            w_dp    = r_act_dp[i];
         end
      end
   end

   assign w_lz_cur = w_lz[r_idx];
   assign w_onehot = N_DIGITS'(1) << r_idx;

   // Gated by enable so that dropping enable darkens the pins on the very next edge.
   always_comb begin
      w_seg_nxt = 8'h00;
      w_dig_nxt = c_dig_off;
      if (enable && r_state == S_SHOW) begin
         if (w_digit > 4'd9)           w_seg_nxt = 8'b0000_0001;
         else if (lz_en && w_lz_cur)   w_seg_nxt = {7'b0, w_dp};
         else                          w_seg_nxt = {seg7(w_digit), w_dp};
         w_dig_nxt = DIG_ACT_LOW ? ~w_onehot : w_onehot;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_out    <= 8'h00;
         dig_sel    <= c_dig_off;
         frame_done <= 1'b0;
      end else begin
         seg_out    <= w_seg_nxt;
         dig_sel    <= w_dig_nxt;
         frame_done <= w_wrap;
      end
   end

   assign pending = r_pending;

endmodule

`default_nettype wire
